// File: rtl/processor_pkg.sv
// processor_pkg: shared opcodes, condition codes, status bit indices, mux encodings and FSM states.
package processor_pkg;
   localparam logic [3:0] op_NOP = 4'h0;
   localparam logic [3:0] op_LD  = 4'h1;
   localparam logic [3:0] op_STR = 4'h2;
   localparam logic [3:0] op_BRA = 4'h3;
   localparam logic [3:0] op_XOR = 4'h4;
   localparam logic [3:0] op_ADD = 4'h5;
   localparam logic [3:0] op_ROT = 4'h6;
   localparam logic [3:0] op_SHF = 4'h7;
   localparam logic [3:0] op_HLT = 4'h8;
   localparam logic [3:0] op_CMP = 4'h9;

   localparam logic [3:0] cc_A  = 4'h0;
   localparam logic [3:0] cc_P  = 4'h1;
   localparam logic [3:0] cc_E  = 4'h2;
   localparam logic [3:0] cc_C  = 4'h3;
   localparam logic [3:0] cc_N  = 4'h4;
   localparam logic [3:0] cc_Z  = 4'h5;
   localparam logic [3:0] cc_NC = 4'h6;
   localparam logic [3:0] cc_PO = 4'h7;

   localparam int PSR_CARRY    = 0;
   localparam int PSR_PARITY   = 1;
   localparam int PSR_EVEN     = 2;
   localparam int PSR_NEGATIVE = 3;
   localparam int PSR_ZERO     = 4;

   localparam logic [1:0] AS_PC  = 2'd0;
   localparam logic [1:0] AS_SRC = 2'd1;
   localparam logic [1:0] AS_DST = 2'd2;

   localparam logic [1:0] WB_ALU = 2'd0;
   localparam logic [1:0] WB_MEM = 2'd1;
   localparam logic [1:0] WB_IMM = 2'd2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DECODE,
      ST_MEM_RD,
      ST_MEM_WR,
      ST_EXEC,
      ST_HALT
   } state_t;
endpackage

// File: rtl/processor_cond_eval.sv
// processor_cond_eval: evaluates a branch condition code against the status register.
module processor_cond_eval
   import processor_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [4:0] psr,
   output logic       cond_true
);
   always_comb begin
      cond_true = 1'b0;
      case (cond)
         cc_A:    cond_true = 1'b1;
         cc_P:    cond_true = psr[PSR_PARITY];
         cc_E:    cond_true = psr[PSR_EVEN];
         cc_C:    cond_true = psr[PSR_CARRY];
         cc_N:    cond_true = psr[PSR_NEGATIVE];
         cc_Z:    cond_true = psr[PSR_ZERO];
         cc_NC:   cond_true = ~psr[PSR_CARRY];
         cc_PO:   cond_true = ~psr[PSR_PARITY];
         default: cond_true = 1'b0;
      endcase
   end
endmodule

// File: rtl/processor_control_fsm.sv
// processor_control_fsm: multi-cycle fetch/decode/memory/execute sequencer for the accumulator datapath.
// Holds only the state register; every strobe is decoded combinationally from state, IR fields and mem_ack.
module processor_control_fsm
   import processor_pkg::*;
#(
   parameter int NUM_OPCODES = 10
)
(
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] opcode,
   input  logic [3:0] cond,
   input  logic       src_imm,
   input  logic [4:0] psr,
   input  logic       mem_ack,
   output logic       mem_req,
   output logic       mem_we,
   output logic [1:0] addr_sel,
   output logic       ir_load,
   output logic       pc_inc,
   output logic       pc_load,
   output logic       reg_we,
   output logic [1:0] wb_sel,
   output logic       psr_we,
   output logic [3:0] alu_op,
   output logic       halted,
   output logic       illegal_op
);
   state_t r_state, w_next;
   logic   w_cond_true;
   logic   w_illegal;

   processor_cond_eval u_cond (
      .cond      (cond),
      .psr       (psr),
      .cond_true (w_cond_true)
   );

   assign w_illegal = {28'd0, opcode} >= 32'(NUM_OPCODES);

   always_ff @(posedge clk) begin
      r_state <= reset ? ST_IDLE : w_next;
   end

   always_comb begin
      w_next     = r_state;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      addr_sel   = AS_PC;
      ir_load    = 1'b0;
      pc_inc     = 1'b0;
      pc_load    = 1'b0;
      reg_we     = 1'b0;
      wb_sel     = WB_ALU;
      psr_we     = 1'b0;
      alu_op     = 4'd0;
      halted     = 1'b0;
      illegal_op = 1'b0;
      case (r_state)
         ST_IDLE: w_next = ST_FETCH;
         ST_FETCH: begin
            mem_req  = 1'b1;
            addr_sel = AS_PC;
            ir_load  = mem_ack;
            pc_inc   = mem_ack;
            w_next   = mem_ack ? ST_DECODE : ST_FETCH;
         end
         ST_DECODE: begin
            w_next = ST_FETCH;
            if (w_illegal) illegal_op = 1'b1;
            else begin
               case (opcode)
                  op_NOP: w_next = ST_FETCH;
                  op_LD: begin
                     reg_we = src_imm;
                     wb_sel = src_imm ? WB_IMM : WB_ALU;
                     w_next = src_imm ? ST_FETCH : ST_MEM_RD;
                  end
                  op_STR: w_next = ST_MEM_WR;
                  op_BRA: pc_load = w_cond_true;
                  op_XOR, op_ADD, op_ROT, op_SHF, op_CMP: w_next = ST_EXEC;
                  op_HLT: w_next = ST_HALT;
                  default: w_next = ST_FETCH;
               endcase
            end
         end
         ST_MEM_RD: begin
            mem_req  = 1'b1;
            addr_sel = AS_SRC;
            reg_we   = mem_ack;
            wb_sel   = mem_ack ? WB_MEM : WB_ALU;
            w_next   = mem_ack ? ST_FETCH : ST_MEM_RD;
         end
         ST_MEM_WR: begin
            mem_req  = 1'b1;
            mem_we   = 1'b1;
            addr_sel = AS_DST;
            w_next   = mem_ack ? ST_FETCH : ST_MEM_WR;
         end
         ST_EXEC: begin
            alu_op = opcode;
            psr_we = 1'b1;
            wb_sel = WB_ALU;
            reg_we = opcode != op_CMP;
            w_next = ST_FETCH;
         end
         ST_HALT: begin
            halted = 1'b1;
            w_next = ST_HALT;
         end
         default: w_next = ST_IDLE;
      endcase
   end
endmodule

// File: tb/tb_processor_control_fsm.sv
// tb_processor_control_fsm: table vectors, directed corner sequences and random instruction streams
// checked against an instruction-level model of the control unit.
module tb_processor_control_fsm;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] opcode = 4'd0;
   logic [3:0] cond = 4'd0;
   logic       src_imm = 1'b0;
   logic [4:0] psr = 5'd0;
   logic       mem_ack = 1'b0;
   logic       mem_req, mem_we, ir_load, pc_inc, pc_load, reg_we, psr_we, halted, illegal_op;
   logic [1:0] addr_sel, wb_sel;
   logic [3:0] alu_op;
   logic [16:0] got;
   int checks = 0;
   int errors = 0;

   localparam int K_FETCH = 0, K_RD = 1, K_WR = 2, K_EX = 3, K_HALT = 4;

   processor_control_fsm #(.NUM_OPCODES(10)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .cond(cond), .src_imm(src_imm), .psr(psr),
      .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel),
      .ir_load(ir_load), .pc_inc(pc_inc), .pc_load(pc_load), .reg_we(reg_we), .wb_sel(wb_sel),
      .psr_we(psr_we), .alu_op(alu_op), .halted(halted), .illegal_op(illegal_op)
   );

   always #5 clk = ~clk;

   assign got = {mem_req, mem_we, addr_sel, ir_load, pc_inc, pc_load, reg_we, wb_sel,
                 psr_we, alu_op, halted, illegal_op};

   function automatic logic [16:0] ev(bit rq, bit we, logic [1:0] as, bit il, bit pi, bit pl,
                                      bit rw, logic [1:0] wb, bit pw, logic [3:0] al, bit h, bit ill);
      return {rq, we, as, il, pi, pl, rw, wb, pw, al, h, ill};
   endfunction

   function automatic bit cond_ok(logic [3:0] c, logic [4:0] p);
      bit zero, neg, even, par, carry;
      {zero, neg, even, par, carry} = p;
      case (c)
         4'h0: return 1'b1;
         4'h1: return par;
         4'h2: return even;
         4'h3: return carry;
         4'h4: return neg;
         4'h5: return zero;
         4'h6: return !carry;
         4'h7: return !par;
         default: return 1'b0;
      endcase
   endfunction

   task automatic chk(input string nm, input logic [16:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%b exp=%b t=%0t", nm, got, exp, $time);
      end
   endtask

   task automatic set_ir(input logic [3:0] op, input logic [3:0] c);
      opcode = op;
      cond = c;
      src_imm = c[3];
   endtask

   task automatic do_reset();
      reset = 1'b1;
      mem_ack = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1 chk("idle", 17'd0);
      @(negedge clk);
   endtask

   task automatic fetch(input int d);
      for (int i = 0; i < d; i++) begin
         mem_ack = 1'b0;
         set_ir(4'($urandom), 4'($urandom));
         #1 chk("fetch_wait", ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
         @(negedge clk);
      end
      mem_ack = 1'b1;
      #1 chk("fetch_ack", ev(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
   endtask

   task automatic decode(input logic [3:0] op, input logic [3:0] c, input logic [4:0] p, output int kind);
      logic [16:0] e;
      set_ir(op, c);
      psr = p;
      mem_ack = 1'($urandom);
      e = 17'd0;
      kind = K_FETCH;
      if (op >= 4'd10) e = ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      else if (op == 4'h1 && c[3]) e = ev(0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0);
      else if (op == 4'h1) kind = K_RD;
      else if (op == 4'h2) kind = K_WR;
      else if (op == 4'h3) e = ev(0, 0, 0, 0, 0, cond_ok(c, p), 0, 0, 0, 0, 0, 0);
      else if (op == 4'h8) kind = K_HALT;
      else if (op != 4'h0) kind = K_EX;
      #1 chk("decode", e);
      @(negedge clk);
   endtask

   task automatic finish(input int kind, input logic [3:0] op, input int d);
      case (kind)
         K_RD, K_WR: begin
            for (int i = 0; i <= d; i++) begin
               mem_ack = (i == d);
               psr = 5'($urandom);
               if (kind == K_RD)
                  #1 chk(i == d ? "rd_ack" : "rd_wait", ev(1, 0, 1, 0, 0, 0, i == d, i == d ? 2'd1 : 2'd0, 0, 0, 0, 0));
               else
                  #1 chk("wr", ev(1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
               @(negedge clk);
            end
         end
         K_EX: begin
            mem_ack = 1'($urandom);
            #1 chk("exec", ev(0, 0, 0, 0, 0, 0, op != 4'h9, 0, 1, op, 0, 0));
            @(negedge clk);
         end
         K_HALT: begin
            for (int i = 0; i < d; i++) begin
               mem_ack = 1'b1;
               #1 chk("halt", ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
               @(negedge clk);
            end
            do_reset();
         end
         default: ;
      endcase
   endtask

   typedef struct {
      logic [3:0]  op;
      logic [3:0]  c;
      logic [4:0]  p;
      logic [16:0] exp;
   } vec_t;

   vec_t tbl[12];

   initial begin
      int kind;
      logic [3:0] op;
      tbl[0]  = '{4'h3, 4'h5, 5'b10000, ev(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0)};
      tbl[1]  = '{4'h3, 4'h5, 5'b00000, 17'd0};
      tbl[2]  = '{4'h3, 4'h6, 5'b00001, 17'd0};
      tbl[3]  = '{4'h3, 4'h6, 5'b00000, ev(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0)};
      tbl[4]  = '{4'h3, 4'h0, 5'b00000, ev(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0)};
      tbl[5]  = '{4'h3, 4'h9, 5'b11111, 17'd0};
      tbl[6]  = '{4'h3, 4'h1, 5'b00010, ev(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0)};
      tbl[7]  = '{4'h3, 4'h7, 5'b00010, 17'd0};
      tbl[8]  = '{4'h3, 4'h4, 5'b01000, ev(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0)};
      tbl[9]  = '{4'h0, 4'h0, 5'b11111, 17'd0};
      tbl[10] = '{4'h1, 4'h8, 5'b00000, ev(0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0)};
      tbl[11] = '{4'hF, 4'h0, 5'b00000, ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1)};

      do_reset();
      fetch(0);
      // ADD: decode, exec, then back in FETCH
      decode(4'h5, 4'h0, 5'd0, kind);
      finish(kind, 4'h5, 0);
      fetch(0);

      foreach (tbl[i]) begin
         set_ir(tbl[i].op, tbl[i].c);
         psr = tbl[i].p;
         mem_ack = 1'b1;
         #1 chk($sformatf("tbl%0d", i), tbl[i].exp);
         @(negedge clk);
         fetch(0);
      end

      decode(4'h1, 4'h0, 5'd0, kind);
      finish(kind, 4'h1, 3);
      fetch(2);
      decode(4'h2, 4'h3, 5'd0, kind);
      finish(kind, 4'h2, 2);
      fetch(0);
      decode(4'h9, 4'h0, 5'd0, kind);
      finish(kind, 4'h9, 0);
      fetch(0);
      decode(4'h8, 4'h0, 5'd0, kind);
      finish(kind, 4'h8, 20);
      fetch(0);
      decode(4'hC, 4'h0, 5'd0, kind);
      fetch(1);
      decode(4'h0, 4'h0, 5'd0, kind);

      // reset during a stalled fetch aborts it
      mem_ack = 1'b0;
      reset = 1'b1;
      #1 chk("rst_fetch_pre", ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      reset = 1'b0;
      #1 chk("rst_fetch_idle", 17'd0);
      @(negedge clk);
      fetch(0);

      for (int n = 0; n < 300; n++) begin
         op = 4'($urandom);
         decode(op, 4'($urandom), 5'($urandom), kind);
         finish(kind, op, $urandom_range(0, 3));
         fetch($urandom_range(0, 2));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
